// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl
//   Owns a 2^IDX_W-entry table of 2-bit saturating branch counters and the
//   global history register (GHR). After reset it sweeps every entry to
//   strongly-taken, then shares the single table read port between fetch
//   lookups and a small queue of resolved-branch training updates.
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   init_done        high once the post-reset sweep has finished
//   lkp_valid/ready  lookup handshake; lkp_pc supplies the branch PC
//   pred_*           registered prediction, one cycle after an accepted lookup
//   upd_valid/ready  training handshake; upd_idx/upd_taken enqueued at the tail
//   q_count          current update-queue occupancy
//
// Build option
//   PHT_STATS_EN     adds stat_lookups, stat_updates and stat_flips counters
module pht_update_ctrl #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 8,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      init_done,
  input  logic                      lkp_valid,
  output logic                      lkp_ready,
  input  logic [PC_W-1:0]           lkp_pc,
  output logic                      pred_valid,
  output logic                      pred_taken,
  output logic [IDX_W-1:0]          pred_idx,
  output logic [1:0]                pred_ctr,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic                      upd_taken,
`ifdef PHT_STATS_EN
  output logic [31:0]               stat_lookups,
  output logic [31:0]               stat_updates,
  output logic [31:0]               stat_flips,
`endif
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_pht [DEPTH];
  logic [IDX_W-1:0] r_sweep;
  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W-1:0] r_q_idx [QDEPTH];
  logic [QDEPTH-1:0] r_q_tk;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_init_done;
  logic             r_pred_vld_p1;
  logic [1:0]       r_pred_ctr_p1;
  logic [IDX_W-1:0] r_pred_idx_p1;

  logic             w_lkp_ready, w_upd_ready;
  logic             w_lkp_fire, w_upd_fire, w_drain;
  logic [IDX_W-1:0] w_lkp_idx, w_head_idx;
  logic             w_head_tk;
  logic [1:0]       w_head_old, w_head_new;
  logic             w_unused;

  // PC bits outside the index field do not participate in the hash.
  assign w_unused = ^{lkp_pc[PC_W-1:IDX_W+2], lkp_pc[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_lkp_ready = 1'b0;
    w_upd_ready = 1'b0;
    case (r_state)
      ST_INIT: if (r_sweep == '1) w_state_nxt = ST_RUN;
      ST_RUN: begin
        // A full queue blocks lookups so the next cycle is guaranteed to drain.
        w_lkp_ready = (r_count != QFULL);
        w_upd_ready = (r_count != QFULL);
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_lkp_idx  = lkp_pc[IDX_W+1:2] ^ r_ghr;
  assign w_lkp_fire = lkp_valid & w_lkp_ready;
  assign w_upd_fire = upd_valid & w_upd_ready;
  // Lookups own the read port; the queue head drains only on idle cycles.
  assign w_drain    = (r_state == ST_RUN) & ~w_lkp_fire & (r_count != '0);
  assign w_head_idx = r_q_idx[r_head];
  assign w_head_tk  = r_q_tk[r_head];
  assign w_head_old = r_pht[w_head_idx];
  assign w_head_new = ctr_next(w_head_old, w_head_tk);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sweep       <= '0;
      r_ghr         <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_init_done   <= 1'b0;
      r_pred_vld_p1 <= 1'b0;
      r_pred_ctr_p1 <= 2'b00;
      r_pred_idx_p1 <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_sweep <= r_sweep + 1'b1;
        if (r_sweep == '1) r_init_done <= 1'b1;
      end
      // p0 -> p1: table read for an accepted lookup becomes the response
      r_pred_vld_p1 <= w_lkp_fire;
      if (w_lkp_fire) begin
        r_pred_ctr_p1 <= r_pht[w_lkp_idx];
        r_pred_idx_p1 <= w_lkp_idx;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
        r_ghr  <= {r_ghr[IDX_W-2:0], w_head_tk};
      end
      if (w_upd_fire) r_tail <= r_tail + 1'b1;
      case ({w_upd_fire, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Table and queue storage carry no reset; the sweep rewrites the table.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)  r_pht[r_sweep]    <= 2'b11;
    else if (w_drain)        r_pht[w_head_idx] <= w_head_new;
    if (w_upd_fire) begin
      r_q_idx[r_tail] <= upd_idx;
      r_q_tk[r_tail]  <= upd_taken;
    end
  end

`ifdef PHT_STATS_EN
  logic [31:0] r_stat_lkp, r_stat_upd, r_stat_flip;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat_lkp  <= '0;
      r_stat_upd  <= '0;
      r_stat_flip <= '0;
    end else begin
      if (w_lkp_fire) r_stat_lkp <= r_stat_lkp + 1'b1;
      if (w_drain)    r_stat_upd <= r_stat_upd + 1'b1;
      if (w_drain && (w_head_old[1] != w_head_new[1])) r_stat_flip <= r_stat_flip + 1'b1;
    end
  end

  assign stat_lookups = r_stat_lkp;
  assign stat_updates = r_stat_upd;
  assign stat_flips   = r_stat_flip;
`endif

  assign init_done  = r_init_done;
  assign lkp_ready  = w_lkp_ready;
  assign upd_ready  = w_upd_ready;
  assign pred_valid = r_pred_vld_p1;
  assign pred_ctr   = r_pred_ctr_p1;
  assign pred_taken = r_pred_ctr_p1[1];
  assign pred_idx   = r_pred_idx_p1;
  assign q_count    = r_count;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Testbench for pht_update_ctrl (IDX_W=4, QDEPTH=4). Directed scenarios plus
// randomized traffic, each cycle compared against a behavioural table model.
module tb_pht_update_ctrl;

  localparam int PC_W   = 32;
  localparam int IDX_W  = 4;
  localparam int QDEPTH = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              init_done;
  logic              lkp_valid = 1'b0;
  logic              lkp_ready;
  logic [PC_W-1:0]   lkp_pc = '0;
  logic              pred_valid, pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [1:0]        pred_ctr;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic [2:0]        q_count;
`ifdef PHT_STATS_EN
  logic [31:0]       stat_lookups, stat_updates, stat_flips;
`endif

  pht_update_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .resetn(resetn), .init_done(init_done),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_pc(lkp_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .pred_ctr(pred_ctr), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_taken(upd_taken),
`ifdef PHT_STATS_EN
    .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_flips(stat_flips),
`endif
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit m_run, m_done, m_pv;
  int m_sweep, m_ghr, m_pctr, m_pidx;
  int m_tbl [DEPTH];
  int m_qi [$];
  bit m_qt [$];
  int m_sl, m_su, m_sf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rn, input bit lv, input logic [31:0] pc,
                      input bit uv, input int ui, input bit ut);
    int idx, i, old, nw;
    bit t, rdy, lf, uf;
    resetn = rn; lkp_valid = lv; lkp_pc = pc;
    upd_valid = uv; upd_idx = IDX_W'(ui); upd_taken = ut;
    if (!rn) begin
      m_run = 0; m_done = 0; m_sweep = 0; m_ghr = 0; m_pv = 0;
      m_pctr = 0; m_pidx = 0; m_qi.delete(); m_qt.delete();
      m_sl = 0; m_su = 0; m_sf = 0;
    end else if (!m_run) begin
      m_tbl[m_sweep] = 3;
      m_sweep++;
      m_pv = 0;
      if (m_sweep == DEPTH) begin m_run = 1; m_done = 1; end
    end else begin
      rdy = (m_qi.size() != QDEPTH);
      lf = lv && rdy;
      uf = uv && rdy;
      m_pv = lf;
      if (lf) begin
        idx = int'((pc >> 2) & 32'hF) ^ m_ghr;
        m_pctr = m_tbl[idx];
        m_pidx = idx;
        m_sl++;
      end else if (m_qi.size() > 0) begin
        i = m_qi.pop_front();
        t = m_qt.pop_front();
        old = m_tbl[i];
        nw = t ? ((old == 3) ? 3 : old + 1) : ((old == 0) ? 0 : old - 1);
        m_tbl[i] = nw;
        if ((old >= 2) != (nw >= 2)) m_sf++;
        m_su++;
        m_ghr = ((m_ghr << 1) | int'(t)) & 15;
      end
      if (uf) begin m_qi.push_back(ui & 15); m_qt.push_back(ut); end
    end
    @(posedge clk);
    @(negedge clk);
    chk("init_done", init_done, m_done);
    chk("lkp_ready", lkp_ready, (m_run && m_qi.size() != QDEPTH));
    chk("upd_ready", upd_ready, (m_run && m_qi.size() != QDEPTH));
    chk("q_count", q_count, m_qi.size());
    chk("pred_valid", pred_valid, m_pv);
    if (m_pv) begin
      chk("pred_ctr", pred_ctr, m_pctr);
      chk("pred_taken", pred_taken, m_pctr >> 1);
      chk("pred_idx", pred_idx, m_pidx);
    end
`ifdef PHT_STATS_EN
    chk("stat_lookups", stat_lookups, m_sl);
    chk("stat_updates", stat_updates, m_su);
    chk("stat_flips", stat_flips, m_sf);
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_pred_ctr", pred_ctr, 0);
    chk("rst_pred_idx", pred_idx, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_lkp_ready", lkp_ready, 0);

    // Sweep: requests held high must be refused for 16 cycles
    for (int k = 0; k < 15; k++) step(1, 1, 32'h40, 1, 2, 0);
    chk("init_at15", init_done, 0);
    step(1, 1, 32'h40, 1, 2, 0);
    chk("init_at16", init_done, 1);

    // First lookup after sweep
    step(1, 1, 32'h40, 0, 0, 0);
    chk("first_ctr", pred_ctr, 2'b11);
    chk("first_taken", pred_taken, 1);
    chk("first_idx", pred_idx, 0);

    // Four not-taken updates to entry 3
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 3, 0);
    idle(2);
    step(1, 1, 32'h0C, 0, 0, 0);
    chk("nt3_idx", pred_idx, 3);
    chk("nt3_ctr", pred_ctr, 0);
    chk("nt3_taken", pred_taken, 0);

    // Fill queue while lookups keep winning the port
    for (int k = 0; k < 4; k++) step(1, 1, 32'h100 + 4 * k, 1, 5 + k, 1);
    chk("full_q", q_count, 4);
    chk("full_lkp_ready", lkp_ready, 0);
    chk("full_upd_ready", upd_ready, 0);
    step(1, 1, 32'h200, 1, 12, 1);
    chk("drain_q", q_count, 3);
    chk("drain_lkp_ready", lkp_ready, 1);
    idle(4);

    // History: flush to zero, then one taken update
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 9, 0);
    step(1, 0, 0, 1, 10, 1);
    idle(2);
    step(1, 1, 32'h44, 0, 0, 0);
    chk("ghr1_idx", pred_idx, 0);

    // Reset with occupied queue and a live response
    for (int k = 0; k < 3; k++) step(1, 1, $urandom, 1, $urandom_range(0, 15), 1'($urandom));
    chk("pre_rst_q", q_count, 3);
    chk("pre_rst_pv", pred_valid, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("mid_rst_q", q_count, 0);
    chk("mid_rst_pv", pred_valid, 0);
    chk("mid_rst_init", init_done, 0);
    idle(16);
    step(1, 1, 32'h0C, 0, 0, 0);
    chk("reinit_ctr3", pred_ctr, 2'b11);
    chk("reinit_idx3", pred_idx, 3);

    // Statistics scenario: 5 lookups, 3 drains, one bit-1 flip
    step(0, 0, 0, 0, 0, 0);
    idle(16);
    for (int k = 0; k < 5; k++) step(1, 1, 32'h10 * k, 0, 0, 0);
    step(1, 0, 0, 1, 5, 1);
    step(1, 0, 0, 1, 6, 0);
    step(1, 0, 0, 1, 6, 0);
    idle(2);
`ifdef PHT_STATS_EN
    chk("st_lookups", stat_lookups, 5);
    chk("st_updates", stat_updates, 3);
    chk("st_flips", stat_flips, 1);
`endif

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 399) != 0), 1'($urandom), $urandom,
           1'($urandom), $urandom_range(0, 15), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
